// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// With PIPE_HAZARD_CTRL_PERF_EN defined, the perf counter outputs are added.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 4
);
  logic [REG_ADDR_W-1:0] i_ra1_d;
  logic [REG_ADDR_W-1:0] i_ra2_d;
  logic [1:0]            i_ra_use_d;
  logic [REG_ADDR_W-1:0] i_wa_e;
  logic                  i_load_e;
  logic                  i_branch_taken_e;
  logic                  i_mc_start_e;
  logic                  i_mc_done;
  logic                  o_mc_req;
  logic                  o_stall_f;
  logic                  o_stall_d;
  logic                  o_stall_e;
  logic                  o_flush_d;
  logic                  o_flush_e;
  logic                  o_flush_m;
  logic                  o_timeout;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0]           o_stall_cycles;
  logic [31:0]           o_flush_events;
`endif

  // Datapath side: drives decode/execute status, consumes stall/flush.
  modport master (
    output i_ra1_d, i_ra2_d, i_ra_use_d, i_wa_e, i_load_e,
           i_branch_taken_e, i_mc_start_e, i_mc_done,
    input  o_mc_req, o_stall_f, o_stall_d, o_stall_e,
           o_flush_d, o_flush_e, o_flush_m, o_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,input  o_stall_cycles, o_flush_events
`endif
  );

  // Controller side.
  modport slave (
    input  i_ra1_d, i_ra2_d, i_ra_use_d, i_wa_e, i_load_e,
           i_branch_taken_e, i_mc_start_e, i_mc_done,
    output o_mc_req, o_stall_f, o_stall_d, o_stall_e,
           o_flush_d, o_flush_e, o_flush_m, o_timeout
`ifdef PIPE_HAZARD_CTRL_PERF_EN
   ,output o_stall_cycles, o_flush_events
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use interlock,
// taken-branch redirect, and park-while-busy handshake with the mul/div unit.
// Optional perf counters: define PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int MAX_WAIT   = 64,
  parameter int CNT_W      = 7
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  pipe_hazard_ctrl_if.slave   bus
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               timeout_q;

  logic               load_use;
  logic               mc_tmo;
  logic               mc_req, stall_f, stall_d, stall_e;
  logic               flush_d, flush_e, flush_m;

  // Load-use compare; r0 is an ordinary register here.
  always_comb begin
    load_use = bus.i_load_e &
               ((bus.i_ra_use_d[0] & (bus.i_ra1_d == bus.i_wa_e)) |
                (bus.i_ra_use_d[1] & (bus.i_ra2_d == bus.i_wa_e)));
    mc_tmo   = (state == MC_WAIT) & ~bus.i_mc_done &
               (wait_cnt == CNT_W'(MAX_WAIT - 1));
  end

  // Same-cycle stall/flush decode from state and inputs.
  always_comb begin
    mc_req  = 1'b0;
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    case (state)
      RUN: begin
        if (bus.i_mc_start_e) begin
          mc_req  = 1'b1;
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
          flush_d = bus.i_branch_taken_e;
        end else if (bus.i_branch_taken_e) begin
          // Decode holds a wrong-path instruction, so its hazard is moot.
          flush_d = 1'b1;
          flush_e = 1'b1;
        end else if (load_use) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end
      end
      MC_WAIT: begin
        // Done or timeout releases EX in the same cycle.
        if (!bus.i_mc_done && !mc_tmo) begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs forced low while reset is held.
  always_comb begin
    bus.o_mc_req  = i_reset_n & mc_req;
    bus.o_stall_f = i_reset_n & stall_f;
    bus.o_stall_d = i_reset_n & stall_d;
    bus.o_stall_e = i_reset_n & stall_e;
    bus.o_flush_d = i_reset_n & flush_d;
    bus.o_flush_e = i_reset_n & flush_e;
    bus.o_flush_m = i_reset_n & flush_m;
    bus.o_timeout = timeout_q;
  end

  // Sequencer FSM: wait counter and sticky timeout flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state     <= RUN;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (bus.i_mc_start_e) begin
            state    <= MC_WAIT;
            wait_cnt <= '0;
          end
        end
        MC_WAIT: begin
          if (bus.i_mc_done) begin
            state <= RUN;
          end else if (mc_tmo) begin
            state     <= RUN;
            timeout_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [31:0] stall_cycles_q, flush_events_q;

  // Free-running perf counters, wrap modulo 2^32.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      if (stall_f) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (flush_d) flush_events_q <= flush_events_q + 32'd1;
    end
  end

  assign bus.o_stall_cycles = stall_cycles_q;
  assign bus.o_flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MAX_WAIT=8). Inputs change and outputs
// are sampled mid low-phase, away from the rising edge.
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(4)) bus ();

  pipe_hazard_ctrl #(.REG_ADDR_W(4), .MAX_WAIT(8), .CNT_W(4)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  // {mc_req, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m}
  localparam logic [6:0] IDLE = 7'b000_0000;
  localparam logic [6:0] LDU  = 7'b011_0010;
  localparam logic [6:0] BR   = 7'b000_0110;
  localparam logic [6:0] MCS  = 7'b111_1001;
  localparam logic [6:0] MCSB = 7'b111_1101;
  localparam logic [6:0] MCW  = 7'b011_1001;

  function automatic logic [6:0] outs();
    return {bus.o_mc_req, bus.o_stall_f, bus.o_stall_d, bus.o_stall_e,
            bus.o_flush_d, bus.o_flush_e, bus.o_flush_m};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic clr();
    bus.i_ra1_d = '0; bus.i_ra2_d = '0; bus.i_ra_use_d = '0; bus.i_wa_e = '0;
    bus.i_load_e = 0; bus.i_branch_taken_e = 0; bus.i_mc_start_e = 0; bus.i_mc_done = 0;
  endtask

  task automatic ldu(input logic [3:0] wa, input logic [3:0] r1, input logic [3:0] r2,
                     input logic [1:0] use_d);
    bus.i_load_e = 1; bus.i_wa_e = wa; bus.i_ra1_d = r1; bus.i_ra2_d = r2;
    bus.i_ra_use_d = use_d;
  endtask

  // Advance to next sample point (after the rising edge, at falling edge).
  task automatic nxt();
    @(negedge clk); #1;
  endtask

  initial begin
    clr();
    // Reset: hazard inputs present but outputs gated low.
    ldu(4'd3, 4'd3, 4'd0, 2'b01);
    bus.i_branch_taken_e = 1;
    #3;
    chk("reset_outs", 32'(outs()), 32'(IDLE));
    chk("reset_timeout", 32'(bus.o_timeout), 0);
    @(negedge clk); rst_n = 1; clr(); #1;
    chk("idle", 32'(outs()), 32'(IDLE));

    // Load-use on ra1, one cycle, then load drops.
    ldu(4'd3, 4'd3, 4'd0, 2'b01); #1;
    chk("ldu_ra1", 32'(outs()), 32'(LDU));
    nxt(); clr(); #1;
    chk("ldu_after", 32'(outs()), 32'(IDLE));

    // Masked compare: ra2 matches but only ra1 is read.
    ldu(4'd3, 4'd5, 4'd3, 2'b01); #1;
    chk("ldu_masked", 32'(outs()), 32'(IDLE));
    ldu(4'd3, 4'd5, 4'd3, 2'b10); #1;
    chk("ldu_ra2", 32'(outs()), 32'(LDU));
    ldu(4'd0, 4'd0, 4'd7, 2'b01); #1;
    chk("ldu_r0", 32'(outs()), 32'(LDU));
    bus.i_load_e = 0; #1;
    chk("no_load", 32'(outs()), 32'(IDLE));

    // Branch overrides load-use.
    ldu(4'd3, 4'd3, 4'd0, 2'b01); bus.i_branch_taken_e = 1; #1;
    chk("branch_vs_ldu", 32'(outs()), 32'(BR));
    nxt(); clr(); #1;

    // Multi-cycle op, done 4 cycles after req.
    bus.i_mc_start_e = 1; #1;
    chk("mc_start", 32'(outs()), 32'(MCS));
    nxt(); clr(); #1;
    chk("mc_wait1", 32'(outs()), 32'(MCW));
    nxt();
    // Branch/start/load-use ignored while parked.
    ldu(4'd3, 4'd3, 4'd0, 2'b01); bus.i_branch_taken_e = 1; bus.i_mc_start_e = 1; #1;
    chk("mc_wait2_ignore", 32'(outs()), 32'(MCW));
    nxt(); clr(); #1;
    chk("mc_wait3", 32'(outs()), 32'(MCW));
    nxt(); bus.i_mc_done = 1; #1;
    chk("mc_done", 32'(outs()), 32'(IDLE));
    nxt(); clr(); #1;
    chk("mc_after", 32'(outs()), 32'(IDLE));
    chk("mc_no_timeout", 32'(bus.o_timeout), 0);
    bus.i_mc_done = 1; #1;
    chk("done_in_run", 32'(outs()), 32'(IDLE));
    nxt(); clr(); #1;

    // Start coincident with taken branch, done one cycle later.
    bus.i_mc_start_e = 1; bus.i_branch_taken_e = 1; #1;
    chk("mc_start_br", 32'(outs()), 32'(MCSB));
    nxt(); clr(); bus.i_mc_done = 1; #1;
    chk("mc_done_fast", 32'(outs()), 32'(IDLE));
    nxt(); clr(); #1;

    // Timeout: 8 MC_WAIT cycles with no done.
    bus.i_mc_start_e = 1; #1;
    chk("tmo_start", 32'(outs()), 32'(MCS));
    nxt(); clr(); #1;
    for (int i = 1; i <= 7; i++) begin
      chk($sformatf("tmo_wait%0d", i), 32'({outs(), bus.o_timeout}), 32'({MCW, 1'b0}));
      nxt();
    end
    nxt();
    chk("tmo_flag", 32'(bus.o_timeout), 1);
    chk("tmo_released", 32'(outs()), 32'(IDLE));
    nxt();
    chk("tmo_sticky", 32'(bus.o_timeout), 1);

    // Async reset mid-MC_WAIT, asserted away from any edge.
    bus.i_mc_start_e = 1; #1;
    chk("rst_mc_start", 32'(outs()), 32'(MCS));
    nxt(); clr(); #1;
    chk("rst_mc_wait", 32'(outs()), 32'(MCW));
    rst_n = 0; #1;
    chk("rst_mid_outs", 32'(outs()), 32'(IDLE));
    chk("rst_clears_tmo", 32'(bus.o_timeout), 0);
    @(negedge clk); rst_n = 1; bus.i_mc_done = 1; #1;
    chk("rst_done_ignored", 32'(outs()), 32'(IDLE));
    nxt(); clr(); #1;
    chk("rst_in_run", 32'(outs()), 32'(IDLE));
    bus.i_mc_start_e = 1; #1;
    chk("rst_fresh_req", 32'(outs()), 32'(MCS));
    nxt(); clr(); bus.i_mc_done = 1; #1;
    nxt(); clr(); #1;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    rst_n = 0; #1; rst_n = 1; #1;
    chk("perf_reset", bus.o_stall_cycles, 0);
    for (int i = 0; i < 3; i++) begin
      ldu(4'd2, 4'd2, 4'd0, 2'b01); nxt(); clr(); nxt();
    end
    chk("perf_ldu", bus.o_stall_cycles, 3);
    bus.i_mc_start_e = 1; nxt(); clr();
    for (int i = 0; i < 4; i++) nxt();
    bus.i_mc_done = 1; nxt(); clr(); #1;
    chk("perf_stall_cycles", bus.o_stall_cycles, 8);
    chk("perf_flush_zero", bus.o_flush_events, 0);
    bus.i_branch_taken_e = 1; nxt(); clr(); #1;
    chk("perf_flush_one", bus.o_flush_events, 1);
    chk("perf_stall_hold", bus.o_stall_cycles, 8);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
